// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data-memory arbiter
//
// Purpose: default geometry of the data memory, arbitration state encoding
// and the registered response triple returned to each requester.
// Ports: none (package).

package dmem_pkg;

  localparam int DMEM_DW         = 32;
  localparam int DMEM_AW         = 32;
  localparam int DMEM_DEPTH      = 1024;
  localparam int DMEM_MAX_STARVE = 4;

  typedef enum logic {
    CORE_PRI = 1'b0,
    DMA_TURN = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic               rvalid;
    logic [DMEM_DW-1:0] rdata;
    logic               err;
  } dmem_rsp_t;

endpackage

// File: rtl/dmem_rsp_reg.sv
// rtl/dmem_rsp_reg.sv - one-cycle registered response for one requester
//
// Purpose: turns an accept in this cycle into a one-cycle response pulse on
// the next cycle, carrying read data (zero for writes and errors) and the
// out-of-range flag.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_accept       this port was granted and its request accepted
//   i_we           accepted access is a write
//   i_oor          accepted address is out of range
//   i_mem_rd       memory read data for the granted address
//   o_rsp          registered {rvalid, rdata, err}

module dmem_rsp_reg
  import dmem_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_accept,
  input  logic               i_we,
  input  logic               i_oor,
  input  logic [DMEM_DW-1:0] i_mem_rd,
  output dmem_rsp_t          o_rsp
);

  dmem_rsp_t r_rsp;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp <= '0;
    end else begin
      r_rsp.rvalid <= i_accept;
      r_rsp.err    <= i_accept & i_oor;
      // Only an in-range read returns memory contents; everything else is 0.
      r_rsp.rdata  <= (i_accept & ~i_we & ~i_oor) ? i_mem_rd : '0;
    end
  end

  assign o_rsp = r_rsp;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of a single-port data memory
//
// Purpose: shares one 1-port word memory between the core LSU (C) and the
// DMA/debug loader (D). Core has fixed priority; after MAX_STARVE
// consecutive contested core wins the DMA is given one forced turn.
// Responses return registered, one cycle after acceptance.
// Ports:
//   i_clk, i_rst                         clock, synchronous active-high reset
//   i_c_req/i_c_we/i_c_addr/i_c_wdata    core request
//   o_c_ready                            core request accepted (combinational)
//   o_c_rvalid/o_c_rdata/o_c_err         core response
//   i_d_*/o_d_*                          same set for the DMA port
//   o_mem_a/o_mem_wd/o_mem_we            memory address, write data, write enable
//   i_mem_rd                             memory combinational read data

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DW         = DMEM_DW,
  parameter int AW         = DMEM_AW,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int MAX_STARVE = DMEM_MAX_STARVE
) (
  input  logic          i_clk,
  input  logic          i_rst,

  input  logic          i_c_req,
  input  logic          i_c_we,
  input  logic [AW-1:0] i_c_addr,
  input  logic [DW-1:0] i_c_wdata,
  output logic          o_c_ready,
  output logic          o_c_rvalid,
  output logic [DW-1:0] o_c_rdata,
  output logic          o_c_err,

  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_ready,
  output logic          o_d_rvalid,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_d_err,

  output logic [AW-1:0] o_mem_a,
  output logic [DW-1:0] o_mem_wd,
  output logic          o_mem_we,
  input  logic [DW-1:0] i_mem_rd
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [SW-1:0] r_starve_cnt;
  logic [SW-1:0] w_starve_nxt;

  logic          w_c_grant;
  logic          w_d_grant;
  logic          w_c_oor;
  logic          w_d_oor;

  dmem_rsp_t     w_c_rsp;
  dmem_rsp_t     w_d_rsp;

  // Full-width compare so high address bits can never alias into the array.
  assign w_c_oor = (i_c_addr >= AW'(DEPTH));
  assign w_d_oor = (i_d_addr >= AW'(DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= CORE_PRI;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  always_comb begin
    w_c_grant    = 1'b0;
    w_d_grant    = 1'b0;
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    if (!i_rst) begin
      case (r_state)
        CORE_PRI: begin
          w_c_grant = i_c_req;
          w_d_grant = i_d_req & ~i_c_req;
          if (i_c_req && i_d_req) begin
            // Contested core win: count it and hand over once the run is long enough.
            if (r_starve_cnt + SW'(1) >= SW'(MAX_STARVE)) begin
              w_state_nxt  = DMA_TURN;
              w_starve_nxt = '0;
            end else begin
              w_starve_nxt = r_starve_cnt + SW'(1);
            end
          end else begin
            // DMA got the grant or was not waiting: no starvation in progress.
            w_starve_nxt = '0;
          end
        end
        DMA_TURN: begin
          w_d_grant    = i_d_req;
          w_c_grant    = i_c_req & ~i_d_req;
          // The forced turn lasts a single cycle whether or not DMA uses it.
          w_state_nxt  = CORE_PRI;
          w_starve_nxt = '0;
        end
        default: begin
          w_state_nxt  = CORE_PRI;
          w_starve_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    o_mem_a  = '0;
    o_mem_wd = '0;
    o_mem_we = 1'b0;
    if (w_c_grant) begin
      o_mem_a  = i_c_addr;
      o_mem_wd = i_c_wdata;
      o_mem_we = i_c_we & ~w_c_oor;
    end else if (w_d_grant) begin
      o_mem_a  = i_d_addr;
      o_mem_wd = i_d_wdata;
      o_mem_we = i_d_we & ~w_d_oor;
    end
  end

  assign o_c_ready = w_c_grant;
  assign o_d_ready = w_d_grant;

  dmem_rsp_reg u_c_rsp (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_accept (w_c_grant),
    .i_we     (i_c_we),
    .i_oor    (w_c_oor),
    .i_mem_rd (i_mem_rd),
    .o_rsp    (w_c_rsp)
  );

  dmem_rsp_reg u_d_rsp (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_accept (w_d_grant),
    .i_we     (i_d_we),
    .i_oor    (w_d_oor),
    .i_mem_rd (i_mem_rd),
    .o_rsp    (w_d_rsp)
  );

  // Responses are masked while reset is held so an in-flight pulse is dropped
  // in the very cycle reset is raised, not one cycle later.
  assign o_c_rvalid = w_c_rsp.rvalid & ~i_rst;
  assign o_c_err    = w_c_rsp.err & ~i_rst;
  assign o_c_rdata  = i_rst ? '0 : w_c_rsp.rdata;
  assign o_d_rvalid = w_d_rsp.rvalid & ~i_rst;
  assign o_d_err    = w_d_rsp.err & ~i_rst;
  assign o_d_rdata  = i_rst ? '0 : w_d_rsp.rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_ready, c_rvalid, c_err, d_ready, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] mem [0:1023];
  logic        mem_init_done = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_c_req    (c_req),
    .i_c_we     (c_we),
    .i_c_addr   (c_addr),
    .i_c_wdata  (c_wdata),
    .o_c_ready  (c_ready),
    .o_c_rvalid (c_rvalid),
    .o_c_rdata  (c_rdata),
    .o_c_err    (c_err),
    .i_d_req    (d_req),
    .i_d_we     (d_we),
    .i_d_addr   (d_addr),
    .i_d_wdata  (d_wdata),
    .o_d_ready  (d_ready),
    .o_d_rvalid (d_rvalid),
    .o_d_rdata  (d_rdata),
    .o_d_err    (d_err),
    .o_mem_a    (mem_a),
    .o_mem_wd   (mem_wd),
    .o_mem_we   (mem_we),
    .i_mem_rd   (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  // Memory model: filled on the first edge, then posedge write, comb read.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (mem_we) begin
      mem[mem_a[9:0]] <= mem_wd;
    end
  end
  assign mem_rd = mem[mem_a[9:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_c(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
    c_req = req; c_we = we; c_addr = a; c_wdata = wd;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_req = req; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  logic exp_d, prev_d;
  int   dcnt;

  initial begin
    rst = 1'b1;
    drive_c(1, 1, 32'd28, 32'h55);
    drive_d(1, 1, 32'd3, 32'h66);

    // Reset held two cycles with both requesters active
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_c_ready", {31'b0, c_ready}, 0);
      chk("rst_d_ready", {31'b0, d_ready}, 0);
      chk("rst_mem_we", {31'b0, mem_we}, 0);
      chk("rst_c_rvalid", {31'b0, c_rvalid}, 0);
      chk("rst_d_rvalid", {31'b0, d_rvalid}, 0);
      next_cyc();
    end

    // First cycle after reset: core wins, writes DEADBEEF to 28
    rst = 1'b0;
    drive_c(1, 1, 32'd28, 32'hDEAD_BEEF);
    drive_d(1, 0, 32'd5, 32'h0);
    @(negedge clk);
    chk("first_c_ready", {31'b0, c_ready}, 1);
    chk("first_d_ready", {31'b0, d_ready}, 0);
    chk("first_mem_we", {31'b0, mem_we}, 1);
    chk("first_mem_a", mem_a, 32'd28);
    next_cyc();

    // Read back same address on the next cycle
    drive_c(1, 0, 32'd28, 32'h0);
    drive_d(0, 0, 32'd0, 32'h0);
    @(negedge clk);
    chk("wr_ack_rvalid", {31'b0, c_rvalid}, 1);
    chk("wr_ack_rdata", c_rdata, 0);
    chk("wr_ack_err", {31'b0, c_err}, 0);
    chk("wr_ack_d_rvalid", {31'b0, d_rvalid}, 0);
    next_cyc();

    drive_c(0, 0, 32'd0, 32'h0);
    @(negedge clk);
    chk("rd28_rvalid", {31'b0, c_rvalid}, 1);
    chk("rd28_rdata", c_rdata, 32'hDEAD_BEEF);
    chk("rd28_err", {31'b0, c_err}, 0);
    chk("idle_mem_we", {31'b0, mem_we}, 0);
    chk("idle_mem_a", mem_a, 0);
    next_cyc();

    // Contention: grant pattern C,C,C,C,D repeating; DMA reads in order
    prev_d = 1'b0;
    dcnt   = 0;
    for (int k = 0; k < 10; k++) begin
      drive_c(1, 0, 32'(100 + k), 32'h0);
      drive_d(1, 0, 32'(200 + dcnt), 32'h0);
      @(negedge clk);
      exp_d = ((k % 5) == 4);
      chk($sformatf("cont%0d_d_ready", k), {31'b0, d_ready}, {31'b0, exp_d});
      chk($sformatf("cont%0d_c_ready", k), {31'b0, c_ready}, {31'b0, ~exp_d});
      if (k > 0) begin
        chk($sformatf("cont%0d_d_rvalid", k), {31'b0, d_rvalid}, {31'b0, prev_d});
        chk($sformatf("cont%0d_c_rvalid", k), {31'b0, c_rvalid}, {31'b0, ~prev_d});
        if (prev_d) chk($sformatf("cont%0d_d_rdata", k), d_rdata, init_val(200 + dcnt - 1));
        else        chk($sformatf("cont%0d_c_rdata", k), c_rdata, init_val(100 + k - 1));
      end
      if (exp_d) dcnt++;
      prev_d = exp_d;
      next_cyc();
    end
    drive_c(0, 0, 32'd0, 32'h0);
    drive_d(0, 0, 32'd0, 32'h0);
    @(negedge clk);
    chk("cont_last_d_rvalid", {31'b0, d_rvalid}, 1);
    chk("cont_last_d_rdata", d_rdata, init_val(201));
    next_cyc();

    // Out-of-range DMA write at DEPTH
    drive_d(1, 1, 32'd1024, 32'h1);
    @(negedge clk);
    chk("oor_d_ready", {31'b0, d_ready}, 1);
    chk("oor_mem_we", {31'b0, mem_we}, 0);
    next_cyc();
    drive_d(1, 0, 32'd0, 32'h0);
    @(negedge clk);
    chk("oor_d_rvalid", {31'b0, d_rvalid}, 1);
    chk("oor_d_err", {31'b0, d_err}, 1);
    chk("oor_d_rdata", d_rdata, 0);
    next_cyc();
    drive_d(0, 0, 32'd0, 32'h0);
    @(negedge clk);
    chk("addr0_d_rvalid", {31'b0, d_rvalid}, 1);
    chk("addr0_d_err", {31'b0, d_err}, 0);
    chk("addr0_d_rdata", d_rdata, init_val(0));
    next_cyc();

    // High address bits set: must not alias onto word 5
    drive_c(1, 1, 32'h0001_0005, 32'hBAD0_0001);
    @(negedge clk);
    chk("hi_oor_mem_we", {31'b0, mem_we}, 0);
    next_cyc();
    // Last legal word is writable
    drive_c(1, 1, 32'd1023, 32'hA5A5_5A5A);
    @(negedge clk);
    chk("hi_oor_c_err", {31'b0, c_err}, 1);
    chk("top_mem_we", {31'b0, mem_we}, 1);
    next_cyc();
    drive_c(1, 0, 32'd5, 32'h0);
    @(negedge clk);
    chk("top_c_err", {31'b0, c_err}, 0);
    next_cyc();
    drive_c(1, 0, 32'd1023, 32'h0);
    @(negedge clk);
    chk("addr5_c_rdata", c_rdata, init_val(5));
    next_cyc();
    drive_c(0, 0, 32'd0, 32'h0);
    @(negedge clk);
    chk("top_c_rdata", c_rdata, 32'hA5A5_5A5A);
    next_cyc();

    // Four contested core wins, then DMA drops out of its forced turn
    for (int k = 0; k < 4; k++) begin
      drive_c(1, 0, 32'd10, 32'h0);
      drive_d(1, 0, 32'd11, 32'h0);
      @(negedge clk);
      chk($sformatf("pre_drop%0d_c_ready", k), {31'b0, c_ready}, 1);
      next_cyc();
    end
    drive_d(0, 0, 32'd0, 32'h0);
    @(negedge clk);
    chk("drop_c_ready", {31'b0, c_ready}, 1);
    chk("drop_d_ready", {31'b0, d_ready}, 0);
    next_cyc();
    // Back in CORE_PRI with counter cleared: full C,C,C,C,D run again
    for (int k = 0; k < 5; k++) begin
      drive_c(1, 0, 32'd10, 32'h0);
      drive_d(1, 0, 32'd11, 32'h0);
      @(negedge clk);
      exp_d = (k == 4);
      chk($sformatf("post_drop%0d_d_ready", k), {31'b0, d_ready}, {31'b0, exp_d});
      chk($sformatf("post_drop%0d_c_ready", k), {31'b0, c_ready}, {31'b0, ~exp_d});
      next_cyc();
    end
    drive_c(0, 0, 32'd0, 32'h0);
    drive_d(0, 0, 32'd0, 32'h0);
    next_cyc();

    // Reset right after a core read is accepted
    drive_c(1, 0, 32'd28, 32'h0);
    @(negedge clk);
    chk("mid_rd_c_ready", {31'b0, c_ready}, 1);
    next_cyc();
    rst = 1'b1;
    drive_c(1, 1, 32'd28, 32'h0);
    @(negedge clk);
    chk("mid_rst_c_rvalid", {31'b0, c_rvalid}, 0);
    chk("mid_rst_c_ready", {31'b0, c_ready}, 0);
    chk("mid_rst_mem_we", {31'b0, mem_we}, 0);
    next_cyc();
    rst = 1'b0;
    drive_c(1, 0, 32'd28, 32'h0);
    @(negedge clk);
    chk("post_rst_c_rvalid", {31'b0, c_rvalid}, 0);
    chk("post_rst_c_ready", {31'b0, c_ready}, 1);
    next_cyc();
    drive_c(0, 0, 32'd0, 32'h0);
    @(negedge clk);
    chk("post_rst_rd_rvalid", {31'b0, c_rvalid}, 1);
    chk("post_rst_rd_rdata", c_rdata, 32'hDEAD_BEEF);
    next_cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port word-addressed data memory (1024 x 32, combinational read, posedge write) between two requesters: the core load/store unit (port C) and the DMA/debug loader (port D). Core has fixed priority, with a starvation guard that forces a DMA grant after a bounded run of contested core wins. Read data and write acks return on a registered response channel one cycle after acceptance. Out-of-range accesses are flagged and suppressed. The block sits between both requesters and the data memory, which it drives exclusively.

## Interface
- DW, 32, data width
- AW, 32, address width (word address, indexes memory directly)
- DEPTH, 1024, memory words; legal addresses 0..DEPTH-1
- MAX_STARVE, 4, consecutive contested core wins before DMA is forced (>=1)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- c_req / d_req  in  1  request valid, held until accepted
- c_we / d_we  in  1  1 = write, 0 = read
- c_addr / d_addr  in  AW  word address
- c_wdata / d_wdata  in  DW  write data
- c_ready / d_ready  out  1  request accepted this cycle (combinational)
- c_rvalid / d_rvalid  out  1  one-cycle response pulse
- c_rdata / d_rdata  out  DW  read data (0 for writes and errors)
- c_err / d_err  out  1  out-of-range access, qualified by rvalid
- mem_a  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_we  out  1  memory write enable
- mem_rd  in  DW  memory combinational read data

## Operation
- Accept = req & ready. At most one of c_ready/d_ready high per cycle; both 0 while rst=1.
- FSM (2 states): CORE_PRI, DMA_TURN. Reset -> CORE_PRI, starve_cnt=0.
- CORE_PRI: c_req wins if present; else d_req wins. Contested core win (c_req & d_req): starve_cnt++; when starve_cnt reaches MAX_STARVE -> DMA_TURN, starve_cnt=0. DMA grant or d_req=0 clears starve_cnt.
- DMA_TURN: d_req wins if present (-> CORE_PRI after its grant); if d_req=0, c_req served and state -> CORE_PRI.
- Granted port drives mem_a/mem_wd; mem_we = granted & we & (addr < DEPTH). No grant: mem_a=0, mem_wd=0, mem_we=0.
- Out-of-range (addr >= DEPTH, full AW compare): no write, response err=1, rdata=0.
- Read response: rdata <= mem_rd sampled at the accepting edge. Write response: rvalid with rdata=0, err per range.

## Timing
- Reset values: all rvalid=0, rdata=0, err=0; state CORE_PRI; starve_cnt=0.
- Request-to-ready: 0 cycles (combinational). Accept-to-rvalid: exactly 1 cycle, 1-cycle pulse, no backpressure on responses.
- Back-to-back accepts on the same port every cycle allowed; one response per accept, in order.
- Write at cycle N then read same address at N+1 returns the new data.
- Requester changing addr/we/wdata while req high and not accepted: allowed; value at acceptance is used.
- rst asserted mid-operation: in-flight response dropped (rvalid=0 next cycle), FSM and counter cleared, no memory write in the reset cycle.

## Structure
- Package dmem_pkg: DW, AW, DEPTH, MAX_STARVE defaults; arb_state_t enum {CORE_PRI, DMA_TURN}; response struct {rvalid, rdata, err}.
- Sub-module dmem_rsp_reg, instantiated twice (C, D): registers accept/range/mem_rd into the response triple, synchronous clear on rst.
- Arbitration FSM and starve_cnt (width $clog2(MAX_STARVE+1)) live in the top.

## Test plan
- Reset: hold rst 2 cycles with both req high -> ready both 0, mem_we 0, all rvalid 0; release -> core accepted first cycle.
- Core write 0xDEADBEEF to addr 28, next cycle read addr 28 -> c_rvalid one cycle later, c_rdata=0xDEADBEEF, c_err=0.
- Contention: c_req and d_req held every cycle, MAX_STARVE=4 -> grant pattern C,C,C,C,D repeating; DMA responses in order.
- Out-of-range: d write addr 1024 data 0x1 -> mem_we 0, d_rvalid with d_err=1, d_rdata=0; subsequent read of addr 0 unchanged.
- DMA_TURN with d_req dropped: after 4 contested core wins, deassert d_req -> core granted, state returns CORE_PRI, starve_cnt 0.
- Reset mid-read: accept core read, assert rst on the next edge -> no c_rvalid, following traffic resumes normally.
